// File: rtl/intdiv_sd2bin_pkg.sv
// intdiv_sd2bin_pkg: shared SD2 digit encoding for the integer divider datapath.
// A digit is {p,n} with value p-n, so both 2'b00 and 2'b11 mean zero.
package intdiv_sd2bin_pkg;

    typedef logic [1:0] sd2_t;

    localparam sd2_t POS1   = 2'b10;
    localparam sd2_t NEG1   = 2'b01;
    localparam sd2_t ZERO_1 = 2'b00;
    localparam sd2_t ZERO_2 = 2'b11;

    function automatic logic sd2IsPos(input sd2_t d);
        return (d == POS1);
    endfunction

    function automatic logic sd2IsNeg(input sd2_t d);
        return (d == NEG1);
    endfunction

endpackage

// File: rtl/intdiv_otf_step.sv
// intdiv_otf_step: one on-the-fly conversion step. Given the current Q/QM pair
// (QM is always Q-1) and one SD2 digit, produce the next Q/QM pair without a
// carry-propagate adder: each update is a one-bit left shift with a bit appended.
module intdiv_otf_step
    import intdiv_sd2bin_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] i_q,
    input  logic [W-1:0] i_qm,
    input  sd2_t         i_digit,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_qm
);

    // Select the shift source and appended bit per digit; both zero codes fall to the default
    always_comb begin
        o_q  = {i_q[W-2:0], 1'b0};
        o_qm = {i_qm[W-2:0], 1'b1};
        if (sd2IsPos(i_digit)) begin
            o_q  = {i_q[W-2:0], 1'b1};
            o_qm = {i_q[W-2:0], 1'b0};
        end else if (sd2IsNeg(i_digit)) begin
            o_q  = {i_qm[W-2:0], 1'b1};
            o_qm = {i_qm[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/intdiv_sd2bin.sv
// intdiv_sd2bin: digit-serial SD2-to-binary converter. Accepts N magnitude
// digits MSB first, converts them on the fly, applies the SD2 sign that
// arrives with the last digit and holds the signed result behind valid/ready.
module intdiv_sd2bin
    import intdiv_sd2bin_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         abort,
    input  logic         digit_valid,
    output logic         digit_ready,
    input  sd2_t         digit,
    input  sd2_t         sign_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out_result,
    output logic [N-1:0] out_mag,
    output logic         out_neg,
    output logic         out_zero,
    output logic         out_err
);

    localparam int W  = N + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic ST_ACC  = 1'b0;
    localparam logic ST_DONE = 1'b1;

    logic          r_state;
    logic          w_state_next;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_qm;
    logic [W-1:0]  r_result;
    logic [N-1:0]  r_mag;
    logic          r_neg;
    logic          r_zero;
    logic          r_err;

    logic [W-1:0]  w_q_next;
    logic [W-1:0]  w_qm_next;
    logic          w_accept;
    logic          w_last;
    logic          w_err;
    logic          w_zero;
    logic          w_neg;
    logic [W-1:0]  w_result;

    intdiv_otf_step #(.W(W)) u_step (
        .i_q     (r_q),
        .i_qm    (r_qm),
        .i_digit (digit),
        .o_q     (w_q_next),
        .o_qm    (w_qm_next)
    );

    // A digit is only taken in ACC; abort suppresses it
    assign w_accept = (r_state == ST_ACC) && digit_valid && !abort;
    assign w_last   = w_accept && (r_cnt == CW'(N - 1));

    // Derive the signed result from the final Q; a negative stream reports an error and passes Q through
    always_comb begin
        w_err    = w_q_next[N];
        w_zero   = (w_q_next == '0);
        w_neg    = sd2IsNeg(sign_in) && !w_zero && !w_err;
        w_result = w_q_next;
        if (w_neg) begin
            w_result = ~w_q_next + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: abort wins, otherwise leave ACC on the last digit and DONE on the handshake
    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = ST_ACC;
        end else begin
            case (r_state)
                ST_ACC:  if (w_last)    w_state_next = ST_DONE;
                ST_DONE: if (out_ready) w_state_next = ST_ACC;
                default: w_state_next = ST_ACC;
            endcase
        end
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        digit_ready = (r_state == ST_ACC);
        out_valid   = (r_state == ST_DONE);
    end

    // Accumulator, digit counter and result registers; the last digit captures the result and rearms Q/QM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_q      <= '0;
            r_qm     <= '1;
            r_result <= '0;
            r_mag    <= '0;
            r_neg    <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (abort) begin
            r_cnt <= '0;
            r_q   <= '0;
            r_qm  <= '1;
        end else if (w_accept) begin
            if (w_last) begin
                r_cnt    <= '0;
                r_q      <= '0;
                r_qm     <= '1;
                r_result <= w_result;
                r_mag    <= w_q_next[N-1:0];
                r_neg    <= w_neg;
                r_zero   <= w_zero;
                r_err    <= w_err;
            end else begin
                r_cnt <= r_cnt + CW'(1);
                r_q   <= w_q_next;
                r_qm  <= w_qm_next;
            end
        end
    end

    assign out_result = r_result;
    assign out_mag    = r_mag;
    assign out_neg    = r_neg;
    assign out_zero   = r_zero;
    assign out_err    = r_err;

endmodule
